led_pixel_fetch: RTL and testbench
==================================

LED_PIXEL_FETCH -- requirements
Module: led_pixel_fetch

Interface
REQ-001 Parameter WIDTH, default 64, panel columns per row-pair.
REQ-002 Parameter ROWS, default 16, scan rows (half-panel height).
REQ-003 Parameter PLANES, default 8, colour bits per channel.
REQ-004 clk  input  1  single system clock, all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 x  input  6  column index from the scan shifter.
REQ-007 y  input  4  row index from the scan shifter.
REQ-008 latch_in  input  1  row latch strobe from the scan shifter.
REQ-009 oe_in  input  1  row display strobe from the scan shifter.
REQ-010 fb_addr  output  10  framebuffer read address {y,x}.
REQ-011 fb_rdata  input  48  framebuffer word, 1-cycle read latency; [23:0] top pixel, [47:24] bottom pixel; each half is {R[23:16],G[15:8],B[7:0]} relative.
REQ-012 r0,g0,b0,r1,g1,b1  output  1 each  panel colour bits, top (0) and bottom (1) halves.
REQ-013 latch_out, oe_out  output  1 each  latch_in/oe_in delayed to align with colour bits.
REQ-014 plane  output  3  bit-plane currently displayed.

Function
REQ-015 fb_addr shall be registered {y,x}, updated every cycle (stage 1).
REQ-016 Colour outputs shall be registered from fb_rdata (stage 2); total latency x/y -> colour = 2 cycles.
REQ-017 latch_out/oe_out shall be latch_in/oe_in delayed by exactly 2 cycles through a 2-deep shift register.
REQ-018 Each colour bit = bit [plane] of its 8-bit channel field in fb_rdata.
REQ-019 Frame boundary event: oe_in==1 and y==ROWS-1 in the same cycle.
REQ-020 Frame counter fcnt, 8 bits, range 0..254; +1 per frame boundary; 254 wraps to 0.
REQ-021 plane = index of highest set bit of (fcnt+1); plane p therefore holds for 2^p consecutive frames (BCM weighting, 255-frame cycle).
REQ-022 plane and fcnt shall update on the clock edge that samples the frame boundary event, never mid-row.
REQ-023 Colour bits sampled in the cycle plane changes shall use the new plane value.
REQ-024 Back-to-back oe_in with y==ROWS-1 on consecutive cycles shall count as two frame boundaries.
REQ-025 x/y values >= WIDTH/ROWS are not range-checked; address passes through.

Reset
REQ-026 While rst_n==0: fb_addr=0, all colour bits=0, latch_out=0, oe_out=0, delay pipeline cleared, fcnt=0, plane=0.
REQ-027 Reset assertion mid-row shall clear outputs immediately (asynchronous); first valid colour appears 2 cycles after first post-release clock edge.

Structure
REQ-028 Package led_panel_pkg shall hold WIDTH, ROWS, PLANES, fb_rdata field offsets and the fcnt wrap value 254.
REQ-029 Sub-module led_bcm_plane_sel shall contain fcnt and the priority encoder (inputs clk, rst_n, frame_tick; output plane).
REQ-030 Framebuffer RAM is external to this block.

Verification
REQ-031 fb model returns 0xFFFFFF/0x000000 halves; x=5,y=3 at cycle n -> fb_addr=0x0C5 at n+1; r0=g0=b0=1, r1=g1=b1=0 at n+2.
REQ-032 latch_in pulse at cycle n -> latch_out pulse at n+2 only; same for oe_in.
REQ-033 255 frame boundaries from reset -> plane sequence 0 x1, 1 x2, 2 x4, ..., 7 x128 frames, then plane=0 again.
REQ-034 Pixel R=0x80 with plane=7 -> r0=1; same pixel with plane=0..6 -> r0=0.
REQ-035 rst_n low for 1 cycle mid-row during plane=5 -> all outputs 0 immediately, plane=0, fcnt=0 after release.
REQ-036 oe_in with y=14 -> no plane change; oe_in with y=15 -> fcnt increments exactly once.

Source files
------------

// File: rtl/led_panel_pkg.sv
// Shared constants and types for the LED panel pixel fetch path.
// Field offsets describe the 48-bit framebuffer word: two {R,G,B} pixels.
package led_panel_pkg;

    localparam int WIDTH   = 64;
    localparam int ROWS    = 16;
    localparam int PLANES  = 8;

    localparam int CH_W    = 8;
    localparam int PIX_W   = 3 * CH_W;
    localparam int B_OFS   = 0;
    localparam int G_OFS   = 8;
    localparam int R_OFS   = 16;
    localparam int TOP_OFS = 0;
    localparam int BOT_OFS = 24;

    localparam int FCNT_W  = 8;
    localparam int PLANE_W = 3;
    localparam logic [FCNT_W-1:0] FCNT_WRAP = 8'd254;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } pixel_t;

    // Index of the highest set bit; 0 when no bit is set.
    function automatic logic [PLANE_W-1:0] msb_index(input logic [FCNT_W-1:0] v);
        msb_index = '0;
        for (int unsigned i = 0; i < FCNT_W; i++) begin
            if (v[i]) msb_index = PLANE_W'(i);
        end
    endfunction

endpackage

// File: rtl/led_bcm_plane_sel.sv
// Frame counter and bit-plane selector for binary-coded modulation.
// Plane p is shown for 2^p consecutive frames over a 255-frame cycle.
module led_bcm_plane_sel (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_tick,
    output logic [led_panel_pkg::PLANE_W-1:0] plane
);
    import led_panel_pkg::*;

    logic [FCNT_W-1:0] fcnt;
    logic [FCNT_W-1:0] fcnt_nxt;

    always_comb begin
        fcnt_nxt = (fcnt == FCNT_WRAP) ? '0 : fcnt + 1'b1;
    end

    // fcnt_nxt never exceeds 254, so fcnt_nxt+1 cannot overflow 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt  <= '0;
            plane <= '0;
        end else if (frame_tick) begin
            fcnt  <= fcnt_nxt;
            plane <= msb_index(fcnt_nxt + 1'b1);
        end
    end

endmodule

// File: rtl/led_pixel_fetch.sv
// Two-stage pixel fetch: registered framebuffer address, then registered
// colour bits selected by the current BCM plane, with aligned latch/oe.
module led_pixel_fetch #(
    parameter int WIDTH  = led_panel_pkg::WIDTH,
    parameter int ROWS   = led_panel_pkg::ROWS,
    parameter int PLANES = led_panel_pkg::PLANES
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [$clog2(WIDTH)-1:0]               x,
    input  logic [$clog2(ROWS)-1:0]                y,
    input  logic                                   latch_in,
    input  logic                                   oe_in,
    output logic [$clog2(ROWS)+$clog2(WIDTH)-1:0]  fb_addr,
    input  logic [2*led_panel_pkg::PIX_W-1:0]      fb_rdata,
    output logic                                   r0,
    output logic                                   g0,
    output logic                                   b0,
    output logic                                   r1,
    output logic                                   g1,
    output logic                                   b1,
    output logic                                   latch_out,
    output logic                                   oe_out,
    output logic [$clog2(PLANES)-1:0]              plane
);
    import led_panel_pkg::*;

    localparam int Y_W = $clog2(ROWS);

    pixel_t     pix_top;
    pixel_t     pix_bot;
    logic       frame_tick;
    logic [1:0] latch_dly;
    logic [1:0] oe_dly;

    assign pix_top    = fb_rdata[TOP_OFS +: PIX_W];
    assign pix_bot    = fb_rdata[BOT_OFS +: PIX_W];
    assign frame_tick = oe_in && (y == Y_W'(ROWS - 1));
    assign latch_out  = latch_dly[1];
    assign oe_out     = oe_dly[1];

    led_bcm_plane_sel u_plane_sel (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .plane      (plane)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_addr   <= '0;
            latch_dly <= '0;
            oe_dly    <= '0;
            r0        <= 1'b0;
            g0        <= 1'b0;
            b0        <= 1'b0;
            r1        <= 1'b0;
            g1        <= 1'b0;
            b1        <= 1'b0;
        end else begin
            fb_addr   <= {y, x};
            latch_dly <= {latch_dly[0], latch_in};
            oe_dly    <= {oe_dly[0], oe_in};
            r0        <= pix_top.r[plane];
            g0        <= pix_top.g[plane];
            b0        <= pix_top.b[plane];
            r1        <= pix_bot.r[plane];
            g1        <= pix_bot.g[plane];
            b1        <= pix_bot.b[plane];
        end
    end

endmodule

// File: tb/tb_led_pixel_fetch.sv
// Directed bench for led_pixel_fetch: vector table plus hand-written
// sequences for delay alignment, BCM plane sequencing and async reset.
module tb_led_pixel_fetch;

    logic        clk;
    logic        rst_n;
    logic [5:0]  x;
    logic [3:0]  y;
    logic        latch_in;
    logic        oe_in;
    logic [9:0]  fb_addr;
    logic [47:0] fb_rdata;
    logic        r0, g0, b0, r1, g1, b1;
    logic        latch_out, oe_out;
    logic [2:0]  plane;

    logic [47:0] fb_word;
    int          checks;
    int          errors;

    assign fb_rdata = fb_word;

    led_pixel_fetch #(.WIDTH(64), .ROWS(16), .PLANES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .y         (y),
        .latch_in  (latch_in),
        .oe_in     (oe_in),
        .fb_addr   (fb_addr),
        .fb_rdata  (fb_rdata),
        .r0        (r0),
        .g0        (g0),
        .b0        (b0),
        .r1        (r1),
        .g1        (g1),
        .b1        (b1),
        .latch_out (latch_out),
        .oe_out    (oe_out),
        .plane     (plane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  x;
        logic [3:0]  y;
        logic [47:0] word;
        logic [9:0]  exp_addr;
        logic [5:0]  exp_rgb;   // {r0,g0,b0,r1,g1,b1}
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        y     = 4'd15;
        oe_in = 1'b1;
        step();
        oe_in = 1'b0;
        y     = 4'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [5:0] rgb();
        return {r0, g0, b0, r1, g1, b1};
    endfunction

    int exp_fcnt;
    int exp_plane;

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        x        = '0;
        y        = '0;
        latch_in = 1'b0;
        oe_in    = 1'b0;
        fb_word  = '0;

        vecs[0] = '{6'd5,  4'd3,  48'h000000_FFFFFF, 10'h0C5, 6'b111000};
        vecs[1] = '{6'd63, 4'd15, 48'hFFFFFF_000000, 10'h3FF, 6'b000111};
        vecs[2] = '{6'd0,  4'd0,  48'h010000_000100, 10'h000, 6'b010100};
        vecs[3] = '{6'd42, 4'd9,  48'h000001_FE0000, 10'h26A, 6'b000001};
        vecs[4] = '{6'd1,  4'd8,  48'hFEFEFE_FEFEFE, 10'h201, 6'b000000};

        // reset state
        #12;
        chk("rst_addr",  32'(fb_addr), 32'h0);
        chk("rst_rgb",   32'(rgb()), 32'h0);
        chk("rst_latch", 32'(latch_out), 32'h0);
        chk("rst_oe",    32'(oe_out), 32'h0);
        chk("rst_plane", 32'(plane), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // address and colour pipeline at plane 0
        for (int i = 0; i < 5; i++) begin
            x = vecs[i].x;
            y = vecs[i].y;
            step();
            chk("vec_addr", 32'(fb_addr), 32'(vecs[i].exp_addr));
            fb_word = vecs[i].word;
            step();
            chk("vec_rgb", 32'(rgb()), 32'(vecs[i].exp_rgb));
        end
        x = '0;
        y = '0;

        // latch_in / oe_in single pulses arrive exactly two edges later
        latch_in = 1'b1;
        step();
        latch_in = 1'b0;
        chk("latch_n1", 32'(latch_out), 32'h0);
        step();
        chk("latch_n2", 32'(latch_out), 32'h1);
        step();
        chk("latch_n3", 32'(latch_out), 32'h0);
        oe_in = 1'b1;
        step();
        oe_in = 1'b0;
        chk("oe_n1", 32'(oe_out), 32'h0);
        step();
        chk("oe_n2", 32'(oe_out), 32'h1);
        step();
        chk("oe_n3", 32'(oe_out), 32'h0);
        chk("oe_row0_no_frame", 32'(dut.u_plane_sel.fcnt), 32'h0);

        // frame boundary detection only on the last row, back-to-back counts twice
        y = 4'd14; oe_in = 1'b1;
        step();
        oe_in = 1'b0;
        chk("y14_fcnt",  32'(dut.u_plane_sel.fcnt), 32'h0);
        chk("y14_plane", 32'(plane), 32'h0);
        y = 4'd15; oe_in = 1'b1;
        step();
        oe_in = 1'b0;
        chk("y15_fcnt",  32'(dut.u_plane_sel.fcnt), 32'h1);
        chk("y15_plane", 32'(plane), 32'h1);
        oe_in = 1'b1;
        step();
        step();
        oe_in = 1'b0;
        y = 4'd0;
        chk("b2b_fcnt",  32'(dut.u_plane_sel.fcnt), 32'h3);
        chk("b2b_plane", 32'(plane), 32'h2);

        // full 255-frame BCM cycle with an R=0x80 top pixel
        do_reset();
        fb_word  = 48'h000000_800000;
        exp_fcnt = 0;
        step();
        for (int f = 0; f <= 255; f++) begin
            exp_plane = $clog2(exp_fcnt + 2) - 1;
            chk("sweep_plane", 32'(plane), 32'(exp_plane));
            chk("sweep_r0",    32'(r0), (exp_plane == 7) ? 32'h1 : 32'h0);
            if (f < 255) begin
                do_tick();
                exp_fcnt = (exp_fcnt == 254) ? 0 : exp_fcnt + 1;
                step();
            end
        end

        // asynchronous reset mid-row while plane 5 is displayed
        do_reset();
        for (int f = 0; f < 31; f++) do_tick();
        chk("pre_rst_plane", 32'(plane), 32'h5);
        fb_word  = '1;
        x = 6'd7; y = 4'd2;
        latch_in = 1'b1;
        oe_in    = 1'b1;
        step();
        step();
        chk("pre_rst_rgb", 32'(rgb()), 32'h3F);
        chk("pre_rst_oe",  32'(oe_out), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_addr",  32'(fb_addr), 32'h0);
        chk("arst_rgb",   32'(rgb()), 32'h0);
        chk("arst_latch", 32'(latch_out), 32'h0);
        chk("arst_oe",    32'(oe_out), 32'h0);
        chk("arst_plane", 32'(plane), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_fcnt",  32'(dut.u_plane_sel.fcnt), 32'h0);
        chk("rel_plane", 32'(plane), 32'h0);
        step();
        chk("rel_latch1", 32'(latch_out), 32'h0);
        chk("rel_addr",   32'(fb_addr), 32'h087);
        step();
        chk("rel_latch2", 32'(latch_out), 32'h1);
        chk("rel_oe2",    32'(oe_out), 32'h1);
        chk("rel_plane2", 32'(plane), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
